// File: rtl/pcie_tx_arb_pkg.sv
// Shared types and sizing helpers for the PCIe AXIS TX round-robin arbiter.
package pcie_tx_arb_pkg;

  // Channel count limits supported by the arbiter
  localparam int unsigned MIN_CH = 2;
  localparam int unsigned MAX_CH = 16;

  // Upper bound on the sim-only clock-to-q parameter
  localparam int unsigned MAX_TCQ = 100;

  // Arbiter ownership state
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Bits needed to index n channels (at least 1)
  function automatic int unsigned ch_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold the values 0..max_val (at least 1)
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tx_arb_rr_pick.sv
// Round-robin pick: lowest requester at or above ptr, else lowest requester overall.
module tx_arb_rr_pick
  import pcie_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   idx,
  output logic              any
);

  logic [NUM_CH-1:0] mask_hi;
  logic [NUM_CH-1:0] req_hi;

  // Mask off requesters below ptr, then priority-encode the masked and unmasked vectors
  always_comb begin
    mask_hi = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mask_hi[i] = (CH_W'(i) >= ptr);
    end
    req_hi = req & mask_hi;
    any    = |req;
    idx    = '0;
    // Wrap-around candidate: lowest set bit of the full request vector
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) idx = CH_W'(i);
    end
    // Preferred candidate: lowest set bit at or above ptr overrides the wrap choice
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_hi[i]) idx = CH_W'(i);
    end
  end

endmodule

// File: rtl/pcie_tx_arb_rr.sv
// Packet-granular round-robin arbiter merging N TLP sources onto one PCIe AXIS TX port.
module pcie_tx_arb_rr
  import pcie_tx_arb_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned MAX_PKTS     = 0,
  parameter int unsigned TIMEOUT_CYC  = 1024,
  parameter int unsigned TCQ          = 1
) (
  input  logic                             clk,
  input  logic                             sys_rst_n,
  input  logic                             s_axis_tx_tready,
  output logic [C_DATA_WIDTH-1:0]          s_axis_tx_tdata,
  output logic [KEEP_WIDTH-1:0]            s_axis_tx_tkeep,
  output logic                             s_axis_tx_tlast,
  output logic                             s_axis_tx_tvalid,
  output logic                             tx_src_dsc,
  input  logic [NUM_CH-1:0]                ch_req,
  output logic [NUM_CH-1:0]                ch_ack,
  output logic [NUM_CH-1:0]                ch_tready,
  input  logic [NUM_CH*C_DATA_WIDTH-1:0]   ch_tdata,
  input  logic [NUM_CH*KEEP_WIDTH-1:0]     ch_tkeep,
  input  logic [NUM_CH-1:0]                ch_tlast,
  input  logic [NUM_CH-1:0]                ch_tvalid,
  input  logic [NUM_CH-1:0]                ch_src_dsc,
  output logic [$clog2(NUM_CH)-1:0]        grant_id,
  output logic                             timeout_err
);

  localparam int unsigned CH_W   = ch_width(NUM_CH);
  localparam int unsigned PKT_W  = cnt_width(MAX_PKTS);
  localparam int unsigned IDLE_W = cnt_width(TIMEOUT_CYC);

  // Reject unsupported configurations at elaboration
  if (NUM_CH < MIN_CH || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("pcie_tx_arb_rr: NUM_CH must be in 2..16");
  end
  // TCQ is a sim-only parameter kept for wrapper compatibility; the RTL adds no delays
  if (TCQ > MAX_TCQ) begin : g_bad_tcq
    $error("pcie_tx_arb_rr: implausible TCQ value");
  end

  arb_state_e          state_q, state_d;
  logic [NUM_CH-1:0]   ch_ack_q, ch_ack_d;
  logic [CH_W-1:0]     grant_id_q, grant_id_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                in_pkt_q, in_pkt_d;
  logic [PKT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                timeout_err_q, timeout_err_d;

  logic [CH_W-1:0]     pick_idx;
  logic                pick_any;
  logic                beat_c;
  logic                pkt_end_c;
  logic                others_req_c;
  logic                rel_req_c;
  logic                rel_quota_c;
  logic                rel_tmo_c;
  logic [CH_W-1:0]     next_ptr_c;

  tx_arb_rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .req (ch_req),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Output mux straight from the registered grant; non-owners are never ready
  always_comb begin
    s_axis_tx_tdata  = ch_tdata[grant_id_q*C_DATA_WIDTH +: C_DATA_WIDTH];
    s_axis_tx_tkeep  = ch_tkeep[grant_id_q*KEEP_WIDTH +: KEEP_WIDTH];
    s_axis_tx_tlast  = ch_tlast[grant_id_q];
    tx_src_dsc       = ch_src_dsc[grant_id_q];
    s_axis_tx_tvalid = (|ch_ack_q) & ch_tvalid[grant_id_q];
    ch_tready        = ch_ack_q & {NUM_CH{s_axis_tx_tready}};
    ch_ack           = ch_ack_q;
    grant_id         = grant_id_q;
    timeout_err      = timeout_err_q;
  end

  // Beat/packet-end detection and the three release conditions
  always_comb begin
    beat_c       = s_axis_tx_tvalid & s_axis_tx_tready;
    // A discontinued beat terminates the packet exactly like tlast
    pkt_end_c    = beat_c & (s_axis_tx_tlast | tx_src_dsc);
    others_req_c = |(ch_req & ~ch_ack_q);
    next_ptr_c   = (grant_id_q == CH_W'(NUM_CH - 1)) ? '0 : grant_id_q + CH_W'(1);
    // Owner withdrew between packets with nothing presented on the bus
    rel_req_c    = !ch_req[grant_id_q] && !in_pkt_q && !s_axis_tx_tvalid;
    // Quota used up on this packet end while someone else is waiting
    rel_quota_c  = (MAX_PKTS > 0) && pkt_end_c && others_req_c &&
                   (pkt_cnt_q >= PKT_W'(MAX_PKTS - 1));
    // Owner held the grant idle between packets for too long
    rel_tmo_c    = (TIMEOUT_CYC > 0) && !in_pkt_q && !s_axis_tx_tvalid &&
                   (idle_cnt_q == IDLE_W'(TIMEOUT_CYC - 1));
  end

  // Next-state: grant selection in IDLE, packet tracking and release in GRANT
  always_comb begin
    state_d       = state_q;
    ch_ack_d      = ch_ack_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    in_pkt_d      = in_pkt_q;
    pkt_cnt_d     = pkt_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    timeout_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d    = ST_GRANT;
          ch_ack_d   = NUM_CH'(1) << pick_idx;
          grant_id_d = pick_idx;
          in_pkt_d   = 1'b0;
          pkt_cnt_d  = '0;
          idle_cnt_d = '0;
        end
      end

      ST_GRANT: begin
        if (beat_c) begin
          in_pkt_d = !pkt_end_c;
        end
        // Packet counter saturates at the quota when nobody else is asking
        if ((MAX_PKTS > 0) && pkt_end_c && (pkt_cnt_q < PKT_W'(MAX_PKTS))) begin
          pkt_cnt_d = pkt_cnt_q + PKT_W'(1);
        end
        if (beat_c || in_pkt_q) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q != '1) begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
        if (rel_req_c || rel_quota_c || rel_tmo_c) begin
          state_d       = ST_IDLE;
          ch_ack_d      = '0;
          rr_ptr_d      = next_ptr_c;
          in_pkt_d      = 1'b0;
          // A voluntary release in the same cycle is not reported as a timeout
          timeout_err_d = rel_tmo_c && !rel_req_c && !rel_quota_c;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        ch_ack_d = '0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= ST_IDLE;
      ch_ack_q      <= '0;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      in_pkt_q      <= 1'b0;
      pkt_cnt_q     <= '0;
      idle_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_ack_q      <= ch_ack_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      in_pkt_q      <= in_pkt_d;
      pkt_cnt_q     <= pkt_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_pcie_tx_arb_rr.sv
// Directed bench for pcie_tx_arb_rr: instance A (no quota, 16-cycle timeout), instance B (quota 2, no timeout).
module tb_pcie_tx_arb_rr;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_tready;
  logic [3:0]   a_req, b_req;
  logic [3:0]   ch_tvalid, ch_tlast, ch_dsc;
  logic [255:0] ch_tdata;
  logic [31:0]  ch_tkeep;

  logic [63:0]  a_tdata, b_tdata;
  logic [7:0]   a_tkeep, b_tkeep;
  logic         a_tlast, b_tlast, a_tvalid, b_tvalid, a_dsc, b_dsc, a_terr, b_terr;
  logic [3:0]   a_ack, b_ack, a_rdy, b_rdy;
  logic [1:0]   a_gid, b_gid;

  int n_checks = 0;
  int n_errors = 0;

  pcie_tx_arb_rr #(
    .C_DATA_WIDTH (64), .NUM_CH (4), .MAX_PKTS (0), .TIMEOUT_CYC (16), .TCQ (1)
  ) u_dut_a (
    .clk (clk), .sys_rst_n (rst_n), .s_axis_tx_tready (s_tready),
    .s_axis_tx_tdata (a_tdata), .s_axis_tx_tkeep (a_tkeep), .s_axis_tx_tlast (a_tlast),
    .s_axis_tx_tvalid (a_tvalid), .tx_src_dsc (a_dsc),
    .ch_req (a_req), .ch_ack (a_ack), .ch_tready (a_rdy),
    .ch_tdata (ch_tdata), .ch_tkeep (ch_tkeep), .ch_tlast (ch_tlast),
    .ch_tvalid (ch_tvalid), .ch_src_dsc (ch_dsc),
    .grant_id (a_gid), .timeout_err (a_terr)
  );

  pcie_tx_arb_rr #(
    .C_DATA_WIDTH (64), .NUM_CH (4), .MAX_PKTS (2), .TIMEOUT_CYC (0), .TCQ (1)
  ) u_dut_b (
    .clk (clk), .sys_rst_n (rst_n), .s_axis_tx_tready (s_tready),
    .s_axis_tx_tdata (b_tdata), .s_axis_tx_tkeep (b_tkeep), .s_axis_tx_tlast (b_tlast),
    .s_axis_tx_tvalid (b_tvalid), .tx_src_dsc (b_dsc),
    .ch_req (b_req), .ch_ack (b_ack), .ch_tready (b_rdy),
    .ch_tdata (ch_tdata), .ch_tkeep (ch_tkeep), .ch_tlast (ch_tlast),
    .ch_tvalid (ch_tvalid), .ch_src_dsc (ch_dsc),
    .grant_id (b_gid), .timeout_err (b_terr)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one source channel's beat fields
  task automatic set_ch(input int ch, input logic v, input logic [63:0] d,
                        input logic [7:0] k, input logic l, input logic s);
    ch_tvalid[ch]        = v;
    ch_tdata[ch*64 +: 64] = d;
    ch_tkeep[ch*8 +: 8]  = k;
    ch_tlast[ch]         = l;
    ch_dsc[ch]           = s;
  endtask

  // Hold reset for two edges with idle inputs, release just after an edge
  task automatic do_reset();
    rst_n     = 1'b0;
    a_req     = '0;
    b_req     = '0;
    ch_tvalid = '0;
    ch_tlast  = '0;
    ch_dsc    = '0;
    ch_tdata  = '0;
    ch_tkeep  = '0;
    s_tready  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [3:0] exp_b [8] = '{4'h1, 4'h1, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1};

  initial begin
    int b;
    int beats;
    logic tr;

    // Reset state
    do_reset();
    #1;
    check_eq("rst_ack", a_ack, 0);
    check_eq("rst_gid", a_gid, 0);
    check_eq("rst_terr", a_terr, 0);
    check_eq("rst_tvalid", a_tvalid, 0);

    // Test 1: ch1 sends a 3-beat TLP and drops req with tlast
    a_req = 4'b0010;
    s_tready = 1'b1;
    tick();
    check_eq("t1_ack", a_ack, 4'b0010);
    check_eq("t1_gid", a_gid, 1);
    set_ch(1, 1'b1, 64'h11, 8'hFF, 1'b0, 1'b0);
    #1;
    check_eq("t1_tvalid", a_tvalid, 1);
    check_eq("t1_d0", a_tdata, 64'h11);
    check_eq("t1_rdy", a_rdy, 4'b0010);
    tick();
    set_ch(1, 1'b1, 64'h12, 8'hFF, 1'b0, 1'b0);
    #1;
    check_eq("t1_d1", a_tdata, 64'h12);
    tick();
    set_ch(1, 1'b1, 64'h13, 8'h0F, 1'b1, 1'b0);
    a_req = 4'b0000;
    #1;
    check_eq("t1_last", a_tlast, 1);
    check_eq("t1_keep", a_tkeep, 8'h0F);
    check_eq("t1_hold_mid", a_ack, 4'b0010);
    tick();
    set_ch(1, 1'b0, 64'h0, 8'h0, 1'b0, 1'b0);
    #1;
    check_eq("t1_hold_post", a_ack, 4'b0010);
    tick();
    a_req = 4'b0101;
    #1;
    check_eq("t1_released", a_ack, 0);
    check_eq("t1_dead_tvalid", a_tvalid, 0);
    tick();
    check_eq("t1_ptr2_pick", a_ack, 4'b0100);
    a_req = 4'b0000;
    tick();
    check_eq("t1_ptr2_rel", a_ack, 0);

    // Test 2: ch0 and ch2 together; ch2 waits until ch0 drops req, discontinue ends ch2's packet
    do_reset();
    s_tready = 1'b1;
    a_req = 4'b0101;
    set_ch(2, 1'b1, 64'hC2, 8'hFF, 1'b0, 1'b1);
    tick();
    #1;
    check_eq("t2_ack0", a_ack, 4'b0001);
    check_eq("t2_gated", a_tvalid, 0);
    check_eq("t2_rdy0", a_rdy, 4'b0001);
    set_ch(0, 1'b1, 64'hA0, 8'hFF, 1'b1, 1'b0);
    #1;
    check_eq("t2_d0", a_tdata, 64'hA0);
    tick();
    set_ch(0, 1'b0, 64'h0, 8'h0, 1'b0, 1'b0);
    a_req = 4'b0100;
    #1;
    check_eq("t2_hold0", a_ack, 4'b0001);
    check_eq("t2_gated2", a_tvalid, 0);
    tick();
    check_eq("t2_dead", a_ack, 0);
    check_eq("t2_dead_tvalid", a_tvalid, 0);
    tick();
    check_eq("t2_ack2", a_ack, 4'b0100);
    check_eq("t2_gid2", a_gid, 2);
    check_eq("t2_d2", a_tdata, 64'hC2);
    check_eq("t2_dsc", a_dsc, 1);
    tick();
    set_ch(2, 1'b0, 64'h0, 8'h0, 1'b0, 1'b0);
    a_req = 4'b0000;
    #1;
    check_eq("t2_hold2", a_ack, 4'b0100);
    tick();
    check_eq("t2_dsc_rel", a_ack, 0);

    // Test 3: quota of 2 single-beat TLPs, ch0 and ch3 alternate
    do_reset();
    s_tready = 1'b1;
    set_ch(0, 1'b1, 64'hA0, 8'hFF, 1'b1, 1'b0);
    set_ch(3, 1'b1, 64'hD3, 8'hFF, 1'b1, 1'b0);
    b_req = 4'b1001;
    for (int k = 0; k < 8; k++) begin
      tick();
      #1;
      check_eq($sformatf("t3_ack%0d", k), b_ack, exp_b[k]);
      if (exp_b[k] != 4'h0) begin
        check_eq($sformatf("t3_data%0d", k), b_tdata, (exp_b[k] == 4'h1) ? 64'hA0 : 64'hD3);
      end
    end

    // Test 4: tready toggling during a 4-beat TLP, req dropped mid-packet
    do_reset();
    a_req = 4'b0001;
    tick();
    check_eq("t4_ack", a_ack, 4'b0001);
    b = 0;
    beats = 0;
    for (int cyc = 0; cyc < 20 && b < 4; cyc++) begin
      tr = (cyc % 2 == 0);
      s_tready = tr;
      set_ch(0, 1'b1, 64'h400 + 64'(b), 8'hFF, (b == 3), 1'b0);
      a_req[0] = (b < 2);
      #1;
      check_eq($sformatf("t4_hold%0d", cyc), a_ack, 4'b0001);
      check_eq($sformatf("t4_data%0d", cyc), a_tdata, 64'h400 + 64'(b));
      check_eq($sformatf("t4_rdy%0d", cyc), a_rdy, {3'b000, tr});
      if (a_tvalid && s_tready) beats++;
      if (tr) b++;
      tick();
    end
    check_eq("t4_beats", beats, 4);
    set_ch(0, 1'b0, 64'h0, 8'h0, 1'b0, 1'b0);
    #1;
    check_eq("t4_hold_end", a_ack, 4'b0001);
    tick();
    check_eq("t4_release", a_ack, 0);

    // Test 5: ch2 idles on its grant, timeout hands over to ch1
    do_reset();
    s_tready = 1'b1;
    a_req = 4'b0100;
    tick();
    check_eq("t5_ack2", a_ack, 4'b0100);
    a_req = 4'b0110;
    for (int k = 2; k <= 16; k++) begin
      tick();
      check_eq($sformatf("t5_hold%0d", k), a_ack, 4'b0100);
      check_eq($sformatf("t5_noerr%0d", k), a_terr, 0);
    end
    tick();
    check_eq("t5_rel", a_ack, 0);
    check_eq("t5_terr", a_terr, 1);
    tick();
    check_eq("t5_ack1", a_ack, 4'b0010);
    check_eq("t5_gid1", a_gid, 1);
    check_eq("t5_terr_pulse", a_terr, 0);

    // Test 6: ch1 withdraws, ch2 starts a packet, reset lands mid-packet
    a_req = 4'b0100;
    tick();
    check_eq("t6_rel1", a_ack, 0);
    tick();
    check_eq("t6_ack2", a_ack, 4'b0100);
    set_ch(2, 1'b1, 64'h66, 8'hFF, 1'b0, 1'b0);
    tick();
    check_eq("t6_midpkt", a_tvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_ack", a_ack, 0);
    check_eq("t6_rst_tvalid", a_tvalid, 0);
    check_eq("t6_rst_rdy", a_rdy, 0);
    check_eq("t6_rst_gid", a_gid, 0);
    do_reset();
    a_req = 4'b0101;
    #1;
    check_eq("t6_post_idle", a_ack, 0);
    tick();
    check_eq("t6_ack0", a_ack, 4'b0001);
    check_eq("t6_gid0", a_gid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound on the whole run
  initial begin
    #200000;
    $display("FAIL watchdog run did not complete got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
